// File: rtl/alu_sig_checker.sv
// MISR signature checker for ALU result streams: compacts accepted result words and
// compares against a golden value. Optional trace buffer when ALU_SIG_TRACE_EN is defined.
module alu_sig_checker #(
    parameter logic [31:0] POLY = 32'h04C11DB7,
    parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] count_i,
    input  logic [31:0] expected_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_out_i,
    output logic        in_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] signature_o,
    output logic [15:0] vec_cnt_o
`ifdef ALU_SIG_TRACE_EN
    ,
    input  logic [2:0]  trace_idx_i,
    output logic [31:0] trace_data_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q;
    logic [31:0] sig_q, sig_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] count_q;
    logic [31:0] exp_q;
    logic        pass_q;
    logic        accept;

    always_comb begin
        sig_d  = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ in_out_i;
        cnt_d  = cnt_q + 16'd1;
        accept = (state_q == S_RUN) && in_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sig_q   <= 32'h0;
            cnt_q   <= 16'h0;
            count_q <= 16'h0;
            exp_q   <= 32'h0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        sig_q   <= SEED;
                        cnt_q   <= 16'h0;
                        count_q <= count_i;
                        exp_q   <= expected_i;
                        // An empty session finishes immediately on the seed itself
                        if (count_i == 16'h0) begin
                            state_q <= S_DONE;
                            pass_q  <= (SEED == expected_i);
                        end else begin
                            state_q <= S_RUN;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == count_q) begin
                            state_q <= S_DONE;
                            pass_q  <= (sig_d == exp_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_RUN);
    assign busy_o      = (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = pass_q;
    assign signature_o = sig_q;
    assign vec_cnt_o   = cnt_q;

`ifdef ALU_SIG_TRACE_EN
    logic [31:0] trace_q [8];
    logic [2:0]  wptr_q;

    // Buffer survives session restarts; only reset clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= 3'd0;
            for (int i = 0; i < 8; i++) trace_q[i] <= 32'h0;
        end else if (accept) begin
            trace_q[wptr_q] <= in_out_i;
            wptr_q          <= wptr_q + 3'd1;
        end
    end

    assign trace_data_o = trace_q[wptr_q - 3'd1 - trace_idx_i];
`endif

endmodule

// File: tb/tb_alu_sig_checker.sv
// Directed bench for alu_sig_checker: per-cycle vector table plus a trace-buffer sequence
// when ALU_SIG_TRACE_EN is defined.
module tb_alu_sig_checker;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [15:0] count;
    logic [31:0] expected, in_out;
    logic        in_ready, busy, done, pass;
    logic [31:0] signature;
    logic [15:0] vec_cnt;
`ifdef ALU_SIG_TRACE_EN
    logic [2:0]  trace_idx;
    logic [31:0] trace_data;
`endif

    int n_checks = 0;
    int n_err    = 0;

    alu_sig_checker #(.POLY(POLY), .SEED(SEED)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .count_i     (count),
        .expected_i  (expected),
        .in_valid_i  (in_valid),
        .in_out_i    (in_out),
        .in_ready_o  (in_ready),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .signature_o (signature),
        .vec_cnt_o   (vec_cnt)
`ifdef ALU_SIG_TRACE_EN
        ,
        .trace_idx_i (trace_idx),
        .trace_data_o(trace_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start;
        logic [15:0] count;
        logic [31:0] expected;
        logic        valid;
        logic [31:0] data;
        logic        rdy, bsy, dn, ps;
        logic [31:0] sig;
        logic [15:0] vc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ d;
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic [15:0] c,
                                input logic [31:0] e, input logic v, input logic [31:0] d,
                                input logic rdy, input logic bsy, input logic dn,
                                input logic ps, input logic [31:0] sg, input logic [15:0] vc);
        vec_t t;
        t.rst = r; t.start = s; t.count = c; t.expected = e; t.valid = v; t.data = d;
        t.rdy = rdy; t.bsy = bsy; t.dn = dn; t.ps = ps; t.sig = sg; t.vc = vc;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [15:0] c,
                         input logic [31:0] e, input logic v, input logic [31:0] d);
        rst = r; start = s; count = c; expected = e; in_valid = v; in_out = d;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] w[4];
    logic [31:0] m1, m2, m3, m4, r1, r2, r3;

    initial begin
        rst = 1'b1; start = 1'b0; count = '0; expected = '0; in_valid = 1'b0; in_out = '0;
`ifdef ALU_SIG_TRACE_EN
        trace_idx = 3'd0;
`endif
        w[0] = 32'h12345678; w[1] = 32'hDEADBEEF; w[2] = 32'h00000000; w[3] = 32'h80000001;
        m1 = misr(SEED, w[0]); m2 = misr(m1, w[1]); m3 = misr(m2, w[2]); m4 = misr(m3, w[3]);
        r1 = misr(SEED, 32'hA); r2 = misr(r1, 32'hB); r3 = misr(r2, 32'hC);

        //                r  s  count  expected      v  data          rdy bsy dn ps sig            vc
        tbl.push_back(mk(1, 0, 16'd0, 32'h0,        0, 32'h0,         0, 0, 0, 0, 32'h0,        16'd0));
        tbl.push_back(mk(0, 1, 16'd0, 32'hFFFFFFFF, 0, 32'h0,         0, 0, 1, 1, SEED,         16'd0));
        tbl.push_back(mk(0, 1, 16'd0, 32'h0,        0, 32'h0,         0, 0, 1, 0, SEED,         16'd0));
        tbl.push_back(mk(0, 1, 16'd1, 32'hFB3EE249, 0, 32'h0,         1, 1, 0, 0, SEED,         16'd0));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, 32'h0,         0, 0, 1, 1, 32'hFB3EE249, 16'd1));
        tbl.push_back(mk(0, 1, 16'd1, 32'hFB3EE249, 0, 32'h0,         1, 1, 0, 0, SEED,         16'd0));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, 32'h1,         0, 0, 1, 0, 32'hFB3EE248, 16'd1));
        // count=4, valid pattern 1,0,0,1,1,0,1 with a stray start in the middle
        tbl.push_back(mk(0, 1, 16'd4, m4,           0, 32'h0,         1, 1, 0, 0, SEED,         16'd0));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, w[0],          1, 1, 0, 0, m1,           16'd1));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        0, 32'h5555AAAA,  1, 1, 0, 0, m1,           16'd1));
        tbl.push_back(mk(0, 1, 16'd2, 32'h0,        0, 32'h0,         1, 1, 0, 0, m1,           16'd1));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, w[1],          1, 1, 0, 0, m2,           16'd2));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, w[2],          1, 1, 0, 0, m3,           16'd3));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        0, 32'hFFFF0000,  1, 1, 0, 0, m3,           16'd3));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, w[3],          0, 0, 1, 1, m4,           16'd4));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, 32'h77777777,  0, 0, 1, 1, m4,           16'd4));
        // reset mid-session after 3 of 5 beats, then valid is ignored
        tbl.push_back(mk(0, 1, 16'd5, 32'h0,        0, 32'h0,         1, 1, 0, 0, SEED,         16'd0));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, 32'hA,         1, 1, 0, 0, r1,           16'd1));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, 32'hB,         1, 1, 0, 0, r2,           16'd2));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, 32'hC,         1, 1, 0, 0, r3,           16'd3));
        tbl.push_back(mk(1, 0, 16'd0, 32'h0,        1, 32'hD,         0, 0, 0, 0, 32'h0,        16'd0));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, 32'hE,         0, 0, 0, 0, 32'h0,        16'd0));
        tbl.push_back(mk(0, 0, 16'd0, 32'h0,        1, 32'hF,         0, 0, 0, 0, 32'h0,        16'd0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].count, tbl[i].expected,
                  tbl[i].valid, tbl[i].data);
            chk("in_ready",  i, {31'h0, in_ready}, {31'h0, tbl[i].rdy});
            chk("busy",      i, {31'h0, busy},     {31'h0, tbl[i].bsy});
            chk("done",      i, {31'h0, done},     {31'h0, tbl[i].dn});
            chk("pass",      i, {31'h0, pass},     {31'h0, tbl[i].ps});
            chk("signature", i, signature,         tbl[i].sig);
            chk("vec_cnt",   i, {16'h0, vec_cnt},  {16'h0, tbl[i].vc});
        end

`ifdef ALU_SIG_TRACE_EN
        // ten beats wrap the 8-entry buffer; newest is 10, seven back is 3
        drive(1, 0, 16'd0, 32'h0, 0, 32'h0);
        drive(0, 1, 16'd10, 32'h0, 0, 32'h0);
        for (int k = 1; k <= 10; k++) drive(0, 0, 16'd0, 32'h0, 1, 32'(k));
        in_valid = 1'b0;
        chk("trace_done", 100, {31'h0, done}, 32'h1);
        trace_idx = 3'd0;
        #1;
        chk("trace_idx0", 100, trace_data, 32'd10);
        trace_idx = 3'd7;
        #1;
        chk("trace_idx7", 100, trace_data, 32'd3);
        trace_idx = 3'd2;
        #1;
        chk("trace_idx2", 100, trace_data, 32'd8);
        // restart keeps the buffer contents
        drive(0, 1, 16'd3, 32'h0, 0, 32'h0);
        trace_idx = 3'd0;
        #1;
        chk("trace_keep", 100, trace_data, 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
